// File: rtl/set_associative_cache_unit_pkg.sv
// cache_unit_pkg: shared clog2, way type, invalid-state default and lock FSM states for the cache unit
package cache_unit_pkg;
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
    localparam int ASSOCIATIVITY_DEFAULT = 4;
    localparam int INVALID_STATE_DEFAULT = 0;
    typedef logic [clog2(ASSOCIATIVITY_DEFAULT)-1:0] way_t;
    typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_e;
endpackage

// File: rtl/set_associative_cache_unit_if.sv
// set_associative_cache_unit_if: cpu port (lookup/write/allocate/release) and snoop port (lookup/state write); slave = cache, master = controllers
interface set_associative_cache_unit_if #(
    parameter int TAG_WIDTH = 8,
    parameter int INDEX_WIDTH = 4,
    parameter int OFFSET_WIDTH = 2,
    parameter int DATA_WIDTH = 16,
    parameter int STATE_WIDTH = 2,
    parameter int ASSOCIATIVITY = 4
);
    import cache_unit_pkg::*;
    localparam int WAY_W = clog2(ASSOCIATIVITY);
    logic [TAG_WIDTH-1:0] cpu_tag_in, cpu_tag_out, snoop_tag_in;
    logic [INDEX_WIDTH-1:0] cpu_index, snoop_index;
    logic [OFFSET_WIDTH-1:0] cpu_offset, snoop_offset;
    logic [DATA_WIDTH-1:0] cpu_data_in, cpu_data_out, snoop_data_out;
    logic [STATE_WIDTH-1:0] cpu_state_in, cpu_state_out, snoop_state_in, snoop_state_out;
    logic cpu_write_tag, cpu_write_state, cpu_write_data, cpu_access, cpu_allocate, cpu_release;
    logic cpu_hit, cpu_locked, snoop_write_state, snoop_hit;
    logic [WAY_W-1:0] cpu_way_out;
    modport master (
        output cpu_tag_in, cpu_index, cpu_offset, cpu_data_in, cpu_state_in, cpu_write_tag, cpu_write_state,
               cpu_write_data, cpu_access, cpu_allocate, cpu_release, snoop_tag_in, snoop_index, snoop_offset,
               snoop_state_in, snoop_write_state,
        input  cpu_hit, cpu_way_out, cpu_tag_out, cpu_state_out, cpu_data_out, cpu_locked, snoop_hit,
               snoop_state_out, snoop_data_out
    );
    modport slave (
        input  cpu_tag_in, cpu_index, cpu_offset, cpu_data_in, cpu_state_in, cpu_write_tag, cpu_write_state,
               cpu_write_data, cpu_access, cpu_allocate, cpu_release, snoop_tag_in, snoop_index, snoop_offset,
               snoop_state_in, snoop_write_state,
        output cpu_hit, cpu_way_out, cpu_tag_out, cpu_state_out, cpu_data_out, cpu_locked, snoop_hit,
               snoop_state_out, snoop_data_out
    );
endinterface

// File: rtl/set_associative_cache_unit_lru.sv
// cache_lru_tracker: per-set LRU age permutations; touch port (set/way/enable) and victim (lowest invalid, else oldest) for query_set
module cache_lru_tracker
    import cache_unit_pkg::*;
#(
    parameter int SETS = 16,
    parameter int ASSOCIATIVITY = 4,
    localparam int SW = clog2(SETS),
    localparam int WW = clog2(ASSOCIATIVITY)
) (
    input  logic clock,
    input  logic reset,
    input  logic touch_en,
    input  logic [SW-1:0] touch_set,
    input  logic [WW-1:0] touch_way,
    input  logic [SW-1:0] query_set,
    input  logic [ASSOCIATIVITY-1:0] invalid_mask,
    output logic [WW-1:0] victim_way
);
    logic [WW-1:0] age [SETS][ASSOCIATIVITY];
    logic [WW-1:0] touch_age;
    assign touch_age = age[touch_set][touch_way];
    always_comb begin
        victim_way = '0;
        for (int w = ASSOCIATIVITY-1; w >= 0; w--) victim_way = age[query_set][w] == WW'(ASSOCIATIVITY-1) ? WW'(w) : victim_way;
        for (int w = ASSOCIATIVITY-1; w >= 0; w--) victim_way = invalid_mask[w] ? WW'(w) : victim_way;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < ASSOCIATIVITY; w++) age[s][w] <= WW'(w);
        end else if (touch_en) begin
            for (int w = 0; w < ASSOCIATIVITY; w++)
                age[touch_set][w] <= WW'(w) == touch_way ? '0 :
                                     age[touch_set][w] < touch_age ? age[touch_set][w] + 1'b1 : age[touch_set][w];
        end
    end
endmodule

// File: rtl/set_associative_cache_unit.sv
// set_associative_cache_unit: N-way snoopy cache storage; clock/reset, cache_number id, bus = cpu lookup/fill port + snoop lookup/state port
module set_associative_cache_unit
    import cache_unit_pkg::*;
#(
    parameter int CACHE_NUMBER = 0,
    parameter int TAG_WIDTH = 8,
    parameter int INDEX_WIDTH = 4,
    parameter int OFFSET_WIDTH = 2,
    parameter int DATA_WIDTH = 16,
    parameter int STATE_WIDTH = 2,
    parameter int INVALID_STATE = INVALID_STATE_DEFAULT,
    parameter int ASSOCIATIVITY = ASSOCIATIVITY_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    output logic [31:0] cache_number,
    set_associative_cache_unit_if.slave bus
);
    localparam int SETS = 1 << INDEX_WIDTH;
    localparam int WORDS = 1 << OFFSET_WIDTH;
    localparam int WAY_W = clog2(ASSOCIATIVITY);
    localparam logic [STATE_WIDTH-1:0] INV = STATE_WIDTH'(INVALID_STATE);
    logic [TAG_WIDTH-1:0] tags [SETS][ASSOCIATIVITY];
    logic [STATE_WIDTH-1:0] states [SETS][ASSOCIATIVITY];
    logic [DATA_WIDTH-1:0] data [SETS][ASSOCIATIVITY][WORDS];
    lock_state_e lock_state;
    logic [WAY_W-1:0] locked_way, hit_way, snoop_way, victim_way, active_way;
    logic [ASSOCIATIVITY-1:0] invalid_mask;
    logic cpu_hit, snoop_hit, locked, touch_en;
    always_comb begin
        cpu_hit = 1'b0;
        hit_way = '0;
        snoop_hit = 1'b0;
        snoop_way = '0;
        invalid_mask = '0;
        for (int w = ASSOCIATIVITY-1; w >= 0; w--) begin
            invalid_mask[w] = states[bus.cpu_index][w] == INV;
            if (!invalid_mask[w] && tags[bus.cpu_index][w] == bus.cpu_tag_in) begin
                cpu_hit = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (states[bus.snoop_index][w] != INV && tags[bus.snoop_index][w] == bus.snoop_tag_in) begin
                snoop_hit = 1'b1;
                snoop_way = WAY_W'(w);
            end
        end
    end
    assign locked = lock_state == LOCKED;
    assign active_way = locked ? locked_way : cpu_hit ? hit_way : victim_way;
    assign touch_en = (locked && bus.cpu_release) || (bus.cpu_access && (cpu_hit || locked));
    cache_lru_tracker #(.SETS(SETS), .ASSOCIATIVITY(ASSOCIATIVITY)) lru (
        .clock(clock),
        .reset(reset),
        .touch_en(touch_en),
        .touch_set(bus.cpu_index),
        .touch_way(active_way),
        .query_set(bus.cpu_index),
        .invalid_mask(invalid_mask),
        .victim_way(victim_way)
    );
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lock_state <= UNLOCKED;
            locked_way <= '0;
        end else if (!locked && bus.cpu_allocate) begin
            lock_state <= LOCKED;
            locked_way <= victim_way;
        end else if (locked && bus.cpu_release) begin
            lock_state <= UNLOCKED;
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < ASSOCIATIVITY; w++) states[s][w] <= INV;
        end else begin
            if (bus.cpu_write_state) states[bus.cpu_index][active_way] <= bus.cpu_state_in;
            if (bus.snoop_write_state && snoop_hit) states[bus.snoop_index][snoop_way] <= bus.snoop_state_in;
        end
    end
    always_ff @(posedge clock) begin
        if (bus.cpu_write_tag) tags[bus.cpu_index][active_way] <= bus.cpu_tag_in;
        if (bus.cpu_write_data) data[bus.cpu_index][active_way][bus.cpu_offset] <= bus.cpu_data_in;
    end
    assign cache_number = 32'(CACHE_NUMBER);
    assign bus.cpu_hit = cpu_hit;
    assign bus.cpu_way_out = active_way;
    assign bus.cpu_tag_out = tags[bus.cpu_index][active_way];
    assign bus.cpu_state_out = states[bus.cpu_index][active_way];
    assign bus.cpu_data_out = data[bus.cpu_index][active_way][bus.cpu_offset];
    assign bus.cpu_locked = locked;
    assign bus.snoop_hit = snoop_hit;
    assign bus.snoop_state_out = snoop_hit ? states[bus.snoop_index][snoop_way] : INV;
    assign bus.snoop_data_out = snoop_hit ? data[bus.snoop_index][snoop_way][bus.snoop_offset] : '0;
endmodule
